mc_control_unit: RTL
====================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 ir_op  input  6  opcode field of the instruction register; stable from ID until return to IF.
REQ-004 ir_func  input  6  funct field of the instruction register.
REQ-005 alu_zero  input  1  ALU result == 0, valid in EXE.
REQ-006 mem_ready  input  1  memory handshake; the access in the current IF or MEM cycle completes this cycle.
REQ-007 cu_aluc  output  4  ALU op: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 1000 sll, 1100 srl, 1110 sra.
REQ-008 cu_alusrca  output  2  A-operand select: 0 PC, 1 reg rs, 2 shamt (zero-extended ir[10:6]).
REQ-009 cu_alusrcb  output  2  B-operand select: 0 reg rt, 1 constant 4, 2 extended imm, 3 extended imm<<2.
REQ-010 cu_sext  output  1  1 sign-extend imm, 0 zero-extend.
REQ-011 cu_iord  output  1  memory address select: 0 PC, 1 ALU-out register.
REQ-012 cu_wpc, cu_wir, cu_wmem, cu_wreg, cu_wtarget  output  1 each  write enables: PC, IR, data memory, register file, branch-target register.
REQ-013 cu_pcsrc  output  2  next-PC select: 0 ALU result, 1 branch-target register, 2 jump address.
REQ-014 cu_regdst, cu_m2reg  output  1 each  write-register select (1 rd, 0 rt); write-data select (1 memory, 0 ALU-out).
REQ-015 cu_illegal  output  1  one-cycle pulse when an undecoded instruction is seen in ID.
REQ-016 cu_state  output  3  current state, for debug.

Function
REQ-017 States SHALL be IF, ID, EXE, MEM and WB; controls are decoded combinationally from the state register and ir_op/ir_func; every unlisted enable is 0.
REQ-018 IF: iord=0, srca=0, srcb=1, aluc=add, pcsrc=0; if mem_ready then wpc=1, wir=1 and go to ID, else hold IF with no enables.
REQ-019 ID: srca=0, srcb=3, sext=1, aluc=add, wtarget=1; j gives wpc=1, pcsrc=2 and goes to IF; an illegal op gives cu_illegal=1 and goes to IF with no PC or register write; otherwise go to EXE.
REQ-020 EXE R-type (add, sub, and, or, xor, sll, srl, sra; funct 20,22,24,25,26,00,02,03 hex): srca=1 (2 for shifts), srcb=0, aluc per REQ-007, then go to WB; an unknown funct counts as illegal in ID.
REQ-021 EXE addi, andi, ori, xori (op 08,0C,0D,0E): srca=1, srcb=2, sext=1 for addi and 0 for the others, then go to WB.
REQ-022 EXE lw/sw (op 23/2B): srca=1, srcb=2, sext=1, aluc=add, then go to MEM.
REQ-023 EXE beq/bne (op 04/05): srca=1, srcb=0, aluc=sub; take the branch when alu_zero==1 for beq or ==0 for bne, giving wpc=1 and pcsrc=1; go to IF either way.
REQ-024 MEM: iord=1; sw asserts wmem=1 while waiting and goes to IF on mem_ready; lw goes to WB on mem_ready; without mem_ready, hold MEM.
REQ-025 WB: wreg=1; regdst=1 for R-type, 0 for I-type; m2reg=1 only for lw; then go to IF.
REQ-026 Latency with mem_ready tied high: j 2 cycles; beq/bne 3; R-type, ALU-immediate and sw 4; lw 5; each extra wait cycle adds exactly 1.
REQ-027 Only the listed enables SHALL be asserted in each state, with no enable active across a state boundary; each write enable is at most one cycle per write, except wmem, which stays high during MEM wait cycles.

Reset
REQ-028 When rst_n=0 at a clock edge, the next state SHALL be IF, regardless of the current state, including a wait in MEM.
REQ-029 While rst_n=0, all write enables and cu_illegal SHALL be 0, and cu_aluc=0000, muxes=0, cu_state=IF; no partial instruction is retired after reset.

Structure
REQ-030 The shared package cpu_pkg SHALL hold the aluc codes, opcode and funct constants, state encoding and mux-select codes; the ALU uses the same aluc constants.
REQ-031 A single combinational sub-module mc_decoder SHALL map ir_op/ir_func to an instruction class, aluc, sext and illegal; the FSM lives in mc_control_unit.

Verification
REQ-032 add (op 00, funct 20), mem_ready=1 -> states IF,ID,EXE,WB; EXE aluc=0000, srca=1, srcb=0; WB wreg=1, regdst=1, m2reg=0.
REQ-033 lw, with mem_ready low for 2 MEM cycles -> MEM lasts 3 cycles with iord=1; WB m2reg=1, regdst=0; total 7 cycles.
REQ-034 beq with alu_zero=1 -> EXE wpc=1, pcsrc=1, aluc=0001; bne with alu_zero=1 -> wpc=0; both next state IF.
REQ-035 sra (funct 03) -> EXE aluc=1110, srca=2; ori (op 0D) -> aluc=0011, sext=0, srcb=2.
REQ-036 Illegal op 3F -> in ID, cu_illegal=1 for 1 cycle, wpc=0, then IF.
REQ-037 rst_n low for one edge during a sw wait in MEM -> next cycle state IF, wmem=0, no wpc or wreg pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: ALU op codes, opcode/funct values,
// FSM state encoding and datapath mux selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_ALUI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_ILL
  } iclass_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1100;
  localparam logic [3:0] ALU_SRA = 4'b1110;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SRA = 6'h03;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS    = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;
  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMM2  = 2'd3;
  localparam logic [1:0] PCSRC_ALU  = 2'd0;
  localparam logic [1:0] PCSRC_TGT  = 2'd1;
  localparam logic [1:0] PCSRC_JMP  = 2'd2;

  // Shift ops are exactly the aluc codes with the top bit set.
  function automatic logic is_shift(input logic [3:0] aluc);
    return aluc[3];
  endfunction

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction decoder: opcode/funct to instruction class,
// ALU operation, immediate extension mode and illegal flag.
module mc_decoder
  import cpu_pkg::*;
(
  input  logic [5:0] ir_op,
  input  logic [5:0] ir_func,
  output logic [2:0] dec_class,
  output logic [3:0] dec_aluc,
  output logic       dec_sext,
  output logic       dec_illegal
);

  iclass_t cls;

  always_comb begin
    cls      = C_ILL;
    dec_aluc = ALU_ADD;
    dec_sext = 1'b0;
    case (ir_op)
      OP_RTYPE: begin
        cls = C_R;
        case (ir_func)
          F_ADD:   dec_aluc = ALU_ADD;
          F_SUB:   dec_aluc = ALU_SUB;
          F_AND:   dec_aluc = ALU_AND;
          F_OR:    dec_aluc = ALU_OR;
          F_XOR:   dec_aluc = ALU_XOR;
          F_SLL:   dec_aluc = ALU_SLL;
          F_SRL:   dec_aluc = ALU_SRL;
          F_SRA:   dec_aluc = ALU_SRA;
          default: cls = C_ILL;
        endcase
      end
      OP_ADDI: begin cls = C_ALUI; dec_aluc = ALU_ADD; dec_sext = 1'b1; end
      OP_ANDI: begin cls = C_ALUI; dec_aluc = ALU_AND; end
      OP_ORI:  begin cls = C_ALUI; dec_aluc = ALU_OR;  end
      OP_XORI: begin cls = C_ALUI; dec_aluc = ALU_XOR; end
      OP_LW:   begin cls = C_LW;   dec_sext = 1'b1; end
      OP_SW:   begin cls = C_SW;   dec_sext = 1'b1; end
      OP_BEQ:  begin cls = C_BEQ;  dec_aluc = ALU_SUB; end
      OP_BNE:  begin cls = C_BNE;  dec_aluc = ALU_SUB; end
      OP_J:    cls = C_J;
      default: cls = C_ILL;
    endcase
  end

  assign dec_class   = cls;
  assign dec_illegal = (cls == C_ILL);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle CPU control FSM (IF/ID/EXE/MEM/WB). Controls are decoded
// combinationally from the state register and the instruction fields.
module mc_control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] ir_op,
  input  logic [5:0] ir_func,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic [3:0] cu_aluc,
  output logic [1:0] cu_alusrca,
  output logic [1:0] cu_alusrcb,
  output logic       cu_sext,
  output logic       cu_iord,
  output logic       cu_wpc,
  output logic       cu_wir,
  output logic       cu_wmem,
  output logic       cu_wreg,
  output logic       cu_wtarget,
  output logic [1:0] cu_pcsrc,
  output logic       cu_regdst,
  output logic       cu_m2reg,
  output logic       cu_illegal,
  output logic [2:0] cu_state
);

  state_t     state_q, state_d;
  logic [2:0] dec_class;
  logic [3:0] dec_aluc;
  logic       dec_sext;
  logic       dec_illegal;
  iclass_t    cls;

  mc_decoder u_decoder (
    .ir_op       (ir_op),
    .ir_func     (ir_func),
    .dec_class   (dec_class),
    .dec_aluc    (dec_aluc),
    .dec_sext    (dec_sext),
    .dec_illegal (dec_illegal)
  );

  assign cls = iclass_t'(dec_class);

  // While rst_n is low every control stays at its zero default.
  always_comb begin
    state_d    = state_q;
    cu_aluc    = ALU_ADD;
    cu_alusrca = SRCA_PC;
    cu_alusrcb = SRCB_RT;
    cu_sext    = 1'b0;
    cu_iord    = 1'b0;
    cu_wpc     = 1'b0;
    cu_wir     = 1'b0;
    cu_wmem    = 1'b0;
    cu_wreg    = 1'b0;
    cu_wtarget = 1'b0;
    cu_pcsrc   = PCSRC_ALU;
    cu_regdst  = 1'b0;
    cu_m2reg   = 1'b0;
    cu_illegal = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          cu_alusrcb = SRCB_FOUR;
          if (mem_ready) begin
            cu_wpc  = 1'b1;
            cu_wir  = 1'b1;
            state_d = S_ID;
          end
        end
        S_ID: begin
          cu_alusrcb = SRCB_IMM2;
          cu_sext    = 1'b1;
          cu_wtarget = 1'b1;
          if (cls == C_J) begin
            cu_wpc   = 1'b1;
            cu_pcsrc = PCSRC_JMP;
            state_d  = S_IF;
          end else if (dec_illegal) begin
            cu_illegal = 1'b1;
            state_d    = S_IF;
          end else begin
            state_d = S_EXE;
          end
        end
        S_EXE: begin
          cu_aluc    = dec_aluc;
          cu_sext    = dec_sext;
          cu_alusrca = SRCA_RS;
          case (cls)
            C_R: begin
              if (is_shift(dec_aluc)) cu_alusrca = SRCA_SHAMT;
              state_d = S_WB;
            end
            C_ALUI: begin
              cu_alusrcb = SRCB_IMM;
              state_d    = S_WB;
            end
            C_LW, C_SW: begin
              cu_alusrcb = SRCB_IMM;
              state_d    = S_MEM;
            end
            C_BEQ, C_BNE: begin
              if ((cls == C_BEQ) == alu_zero) begin
                cu_wpc   = 1'b1;
                cu_pcsrc = PCSRC_TGT;
              end
              state_d = S_IF;
            end
            default: state_d = S_IF;
          endcase
        end
        S_MEM: begin
          cu_iord = 1'b1;
          cu_wmem = (cls == C_SW);
          if (mem_ready) state_d = (cls == C_LW) ? S_WB : S_IF;
        end
        S_WB: begin
          cu_wreg   = 1'b1;
          cu_regdst = (cls == C_R);
          cu_m2reg  = (cls == C_LW);
          state_d   = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  assign cu_state = rst_n ? state_q : S_IF;

endmodule
